// File: rtl/post_add_sub_simd_pkg.sv
// Shared constants for post_add_sub_simd: carry-in source names and the
// lane-count legality check used at elaboration.
package post_add_sub_simd_pkg;

   localparam string CISEL_OPMODE5 = "OPMODE5";
   localparam string CISEL_CARRYIN = "CARRYIN";

   function automatic bit lanes_ok(input int lanes, input int width);
      return ((lanes == 1) || (lanes == 2) || (lanes == 4)) && ((width % lanes) == 0);
   endfunction

endpackage

// File: rtl/post_add_sub_lane.sv
// One LW-bit lane of the post adder: add or subtract with carry-in,
// carry/borrow out in bit LW of the widened result.
module post_add_sub_lane #(
   parameter int LW = 48
)(
   input  logic [LW-1:0] x,
   input  logic [LW-1:0] z,
   input  logic          cin,
   input  logic          sub,
   output logic [LW-1:0] s,
   output logic          cout
);

   logic [LW:0] res;

   // Subtract folds cin into the subtrahend, so bit LW flags a borrow.
   always_comb begin
      res = '0;
      if (sub)
         res = {1'b0, z} - ({1'b0, x} + {{LW{1'b0}}, cin});
      else
         res = {1'b0, x} + {1'b0, z} + {{LW{1'b0}}, cin};
   end

   assign {cout, s} = res;

endmodule

// File: rtl/post_add_sub_simd.sv
// SIMD post adder/subtractor with optional input/output registers and
// P-feedback accumulation. Pattern detect is built with POST_ADD_SUB_SIMD_PATDET_EN.
module post_add_sub_simd
   import post_add_sub_simd_pkg::*;
#(
   parameter int    WIDTH      = 48,
   parameter int    LANES      = 1,
   parameter int    INREG      = 1,
   parameter int    OUTREG     = 1,
   parameter string CARRYINSEL = "OPMODE5"
`ifdef POST_ADD_SUB_SIMD_PATDET_EN
   ,
   parameter logic [WIDTH-1:0] PATTERN = '0,
   parameter logic [WIDTH-1:0] MASK    = '0
`endif
)(
   input  logic             CLK,
   input  logic             rst,
   input  logic             C_ENABLE,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Z,
   input  logic             CARRYIN,
   input  logic             opmode_5,
   input  logic             opmode_7,
   input  logic             acc_en,
   output logic             out_valid,
   output logic [WIDTH-1:0] P,
   output logic [LANES-1:0] CARRYOUT,
   output logic [LANES-1:0] CARRYOUTF
`ifdef POST_ADD_SUB_SIMD_PATDET_EN
   ,
   output logic             PATDET
`endif
);

   localparam int LW      = WIDTH / LANES;
   localparam bit SEL_OP5 = (CARRYINSEL == CISEL_OPMODE5);
   localparam bit SEL_CIN = (CARRYINSEL == CISEL_CARRYIN);

   if (!lanes_ok(LANES, WIDTH)) begin : g_lanes_illegal
      $error("post_add_sub_simd: LANES must be 1, 2 or 4 and divide WIDTH");
   end

   logic             cin_sel;
   logic [WIDTH-1:0] x1, z1, z_eff, sum;
   logic             cin1, sub1, acc1, v1;
   logic [LANES-1:0] co_c;
   logic             pat_c;

   assign cin_sel = SEL_OP5 ? opmode_5 : (SEL_CIN ? CARRYIN : 1'b0);

   if (INREG != 0) begin : g_inreg
      always_ff @(posedge CLK) begin
         if (rst) begin
            v1 <= 1'b0; x1 <= '0; z1 <= '0;
            cin1 <= 1'b0; sub1 <= 1'b0; acc1 <= 1'b0;
         end else if (C_ENABLE) begin
            v1 <= in_valid;
            if (in_valid) begin
               x1 <= X; z1 <= Z;
               cin1 <= cin_sel; sub1 <= opmode_7; acc1 <= acc_en;
            end
         end
      end
   end else begin : g_inbyp
      assign v1   = in_valid;
      assign x1   = X;
      assign z1   = Z;
      assign cin1 = cin_sel;
      assign sub1 = opmode_7;
      assign acc1 = acc_en;
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      post_add_sub_lane #(.LW(LW)) u_lane (
         .x    (x1[k*LW +: LW]),
         .z    (z_eff[k*LW +: LW]),
         .cin  ((k == 0) ? cin1 : 1'b0),
         .sub  (sub1),
         .s    (sum[k*LW +: LW]),
         .cout (co_c[k])
      );
   end

`ifdef POST_ADD_SUB_SIMD_PATDET_EN
   assign pat_c = (((sum ^ PATTERN) & ~MASK) == '0);
`else
   assign pat_c = 1'b0;
`endif

   if (OUTREG != 0) begin : g_outreg
      logic [WIDTH-1:0] p_reg;
      logic [LANES-1:0] co_reg;
      logic             v2, pat_reg;

      // Accumulation replaces Z with the live P register.
      assign z_eff = acc1 ? p_reg : z1;

      always_ff @(posedge CLK) begin
         if (rst) begin
            v2 <= 1'b0; p_reg <= '0; co_reg <= '0; pat_reg <= 1'b0;
         end else if (C_ENABLE) begin
            v2 <= v1;
            if (v1) begin
               p_reg   <= sum;
               co_reg  <= co_c;
               pat_reg <= pat_c;
            end
         end
      end

      assign out_valid = v2;
      assign P         = p_reg;
      assign CARRYOUT  = co_reg;
`ifdef POST_ADD_SUB_SIMD_PATDET_EN
      assign PATDET    = pat_reg;
`endif
   end else begin : g_outbyp
      assign z_eff     = z1;
      assign out_valid = v1;
      assign P         = sum;
      assign CARRYOUT  = co_c;
`ifdef POST_ADD_SUB_SIMD_PATDET_EN
      assign PATDET    = pat_c;
`endif
   end

   assign CARRYOUTF = CARRYOUT;

endmodule
